nibble_serial_add_seq: RTL and testbench

- Sequencer around the 4-bit ripple-carry adder stage (5-bit sum out).
- Accepts a WIDTH-bit operand pair plus carry-in through a valid/ready handshake.
- Presents one nibble per cycle to the external 4-bit adder, LSB nibble first, and captures each 5-bit adder result.
- Chains the carry between nibbles and delivers a WIDTH+1-bit result on an output handshake.

---
 rtl/nibble_serial_add_seq.sv | 113 +++++++++++
 tb/tb_nibble_serial_add_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_seq.sv
// Serial WIDTH-bit adder sequencer: feeds one nibble per cycle to an external
// 4-bit adder stage, LSB first, chaining the carry and assembling the result.
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [4:0]       add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | waiting for an operand pair
  // S_RUN  | stepping nibble r_k through the external adder
  // S_DONE | result held until the downstream handshake
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH:0]   r_result;
  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;

  // out_ready feeds in_ready combinationally so DONE can hand off straight into RUN
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_k == K_LAST);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign result    = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_k == KW'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  // Adder inputs come only from registers, gated to zero outside RUN
  assign add_a   = busy ? w_nib_a : 4'h0;
  assign add_b   = busy ? w_nib_b : 4'h0;
  assign add_cin = busy ? r_carry : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_carry  <= cin;
      r_k      <= '0;
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (r_k == KW'(i)) r_result[4*i +: 4] <= add_sum[3:0];
      end
      r_carry <= add_sum[4];
      if (w_last) begin
        r_result[WIDTH] <= add_sum[4];
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq: table of vectors plus hand-written handshake,
// backpressure, back-to-back, reset and WIDTH=4 sequences; results via a queue.
module tb_nibble_serial_add_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, cin = 1'b0, add_cin, out_valid, out_ready = 1'b1, busy;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  add_a, add_b;
  logic [4:0]  add_sum;
  logic [16:0] result;

  // external 4-bit ripple adder stage
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  nibble_serial_add_seq #(.WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  logic       in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, add_cin4, out_valid4, out_ready4 = 1'b1, busy4;
  logic [3:0] a4 = '0, b4 = '0, add_a4, add_b4;
  logic [4:0] add_sum4, result4;

  assign add_sum4 = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};

  nibble_serial_add_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .busy(busy4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;

  vec_t        vecs[12];
  logic [16:0] sb_q[$];
  logic [16:0] sb_exp;
  logic [3:0]  seq_a[8];
  logic        seq_cin[8];
  int checks = 0, failures = 0, pushes = 0, pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [16:0] e);
    sb_q.push_back(e);
    pushes++;
  endtask

  // Scoreboard: a result leaves the DUT on the edge after out_valid&&out_ready is seen here
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%0h required=none", result);
      end else begin
        sb_exp = sb_q.pop_front();
        pops++;
        chk("sb_result", {15'b0, result}, {15'b0, sb_exp});
      end
    end
  end

  // One full operation from IDLE with out_ready high; returns RUN length
  task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                       input logic [16:0] e, output int lat);
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; a = ai; b = bi; cin = ci;
    push(e);
    tick();
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      seq_a[lat % 8]   = add_a;
      seq_cin[lat % 8] = add_cin;
      tick();
      lat++;
    end
    chk("latency", lat, 4);
    tick();
    chk("ov_drop", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat, t1, t2, w;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000};
    vecs[7] = '{16'hAAAA, 16'h5555, 1'b1, 17'h10000};
    for (int i = 8; i < 12; i++) begin
      vecs[i].a   = 16'($urandom);
      vecs[i].b   = 16'($urandom);
      vecs[i].cin = 1'($urandom);
      vecs[i].exp = {1'b0, vecs[i].a} + {1'b0, vecs[i].b} + {16'b0, vecs[i].cin};
    end

    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", {15'b0, result}, 32'd0);
    chk("rst_add", {23'b0, add_a, add_b, add_cin}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp, lat);
      if (i == 0) chk("add_a_seq", {16'b0, seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'h4321);
      if (i == 1) chk("add_cin_seq", {28'b0, seq_cin[0], seq_cin[1], seq_cin[2], seq_cin[3]}, 32'b0111);
    end

    // backpressure in DONE with new operands waiting
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h0102; b = 16'h0304; cin = 1'b0;
    push(17'h00406);
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin tick(); w++; end
    chk("bp_latency", w, 4);
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_result_hold", {15'b0, result}, 32'h00406);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rel", {31'b0, in_ready}, 32'd1);
    push(17'h03334);
    tick();
    in_valid = 1'b0;
    chk("bp_accept_busy", {31'b0, busy}, 32'd1);
    chk("bp_ov_clear", {31'b0, out_valid}, 32'd0);
    w = 0;
    while (!out_valid && w < 20) begin tick(); w++; end
    chk("bp2_latency", w, 4);
    tick();

    // back-to-back with out_ready tied high
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
    push(17'h01010);
    tick();
    a = 16'h7FFF; b = 16'h0001; cin = 1'b1;
    push(17'h08001);
    t1 = -1; t2 = -1;
    for (int t = 1; t <= 11; t++) begin
      if (out_valid) begin
        if (t1 < 0) begin
          t1 = t;
          chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        end else if (t2 < 0) t2 = t;
      end
      tick();
      if (t == 5) in_valid = 1'b0;
    end
    chk("b2b_first_ov", t1, 5);
    chk("b2b_period", t2 - t1, 5);

    // reset mid-RUN discards the operation
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_outs", {13'b0, out_valid, result, add_a, add_b, add_cin}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    do_op(16'h0001, 16'h0001, 1'b0, 17'h00002, lat);

    // WIDTH=4 instance: RUN is a single cycle
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
    chk("w4_in_ready", {31'b0, in_ready4}, 32'd1);
    tick();
    in_valid4 = 1'b0;
    chk("w4_busy", {31'b0, busy4}, 32'd1);
    chk("w4_add_a", {28'b0, add_a4}, 32'hF);
    tick();
    chk("w4_out_valid", {31'b0, out_valid4}, 32'd1);
    chk("w4_result", {27'b0, result4}, 32'h11);
    tick();
    chk("w4_ov_drop", {31'b0, out_valid4}, 32'd0);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("sb_pops", pops, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
